picorv32_pcpi_sha2_ctrl: RTL and testbench
==========================================

Name: picorv32_pcpi_sha2_ctrl

Overview:
- Parametrised PCPI coprocessor front-end for a SHA-2 family compression core (SHA-224/SHA-256), attached to picorv32 via PCPI.
- Owns the message block buffer, the digest capture buffer, a command FSM with a proper core start/done handshake, a timeout watchdog, an auto-increment load pointer, and a readable status word.
- The hash core sits outside this block on the core_* ports; a behavioural core model is sufficient for verification.

Parameters:
- BLOCK_WORDS, 16, 32-bit words per message block; power of two.
- DIGEST_WORDS, 8, 32-bit words captured from core_digest.
- OPCODE, 7'b0001011, custom-0 opcode matched on pcpi_insn[6:0].
- FUNCT7, 7'b0000000, value matched on pcpi_insn[31:25].
- TIMEOUT_CYCLES, 1024, maximum cycles from START entry to done before aborting; must be ≥2.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- pcpi_valid  in  1  PCPI instruction valid
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1: data word, or mode select in bit 0
- pcpi_rs2  in  32  operand 2: word index
- pcpi_wr  out  1  rd write-back strobe, asserted together with pcpi_ready
- pcpi_rd  out  32  result
- pcpi_wait  out  1  busy indicator for multi-cycle operations
- pcpi_ready  out  1  one-cycle completion pulse
- core_reset_n  out  1  core reset, active-low
- core_init  out  1  one-cycle start of the first block
- core_next  out  1  one-cycle start of a subsequent block
- core_mode  out  1  0 = SHA-224, 1 = SHA-256
- core_block  out  32*BLOCK_WORDS  block[0] occupies the MSBs
- core_ready  in  1  core idle
- core_digest  in  32*DIGEST_WORDS  digest[0] occupies the MSBs
- core_digest_valid  in  1  digest valid

Behaviour:
- Reset:
  - Outputs: pcpi_wr = pcpi_wait = pcpi_ready = 0; pcpi_rd = 0; core_init = core_next = 0; core_reset_n = 0 while reset_n = 0, then 1 from the first cycle after release; core_mode = 1.
  - Internal state: block, digest, ptr, status flags all cleared; FSM to IDLE.
  - Reset mid-operation aborts immediately; no pcpi_ready is issued.
- Decode: accept only when all hold:
  - FSM in IDLE;
  - pcpi_valid = 1;
  - insn[6:0] = OPCODE and insn[31:25] = FUNCT7.
  - Otherwise the block stays silent and never drives pcpi_ready.
- Commands by funct3 (insn[14:12]); unlisted funct3 values are ignored (not accepted):
  - 000 LW: if rs2 < BLOCK_WORDS then block[rs2] <= rs1; out-of-range index writes nothing. pcpi_wr = 0.
  - 110 LWI: block[ptr] <= rs1; ptr <= (ptr+1) mod BLOCK_WORDS; rs2 ignored. pcpi_wr = 0.
  - 001 INIT / 010 NEXT:
    - core_mode <= rs1[0]; ptr <= 0.
    - Runs the hash handshake; on success, digest words are captured from core_digest.
    - pcpi_wr = 0.
  - 011 DIGEST: rd = digest[rs2] if rs2 < DIGEST_WORDS, else 0. pcpi_wr = 1.
  - 100 RESET:
    - Clears block, digest, ptr and flags.
    - Drives core_reset_n = 0 for exactly 2 cycles.
    - Responds after core_reset_n returns to 1; pcpi_wr = 0.
  - 101 STATUS: rd = {24'b0, ptr[3:0] zero-extended, timeout, digest_ok, core_ready, 1'b0}, i.e. bits [7:4] = ptr, bit 3 = timeout, bit 2 = digest_ok, bit 1 = core_ready, bit 0 = 0. pcpi_wr = 1.
- FSM states: IDLE, EXEC, START, WAIT_ACK, WAIT_DONE, CORE_RST, RESP, HOLD.
  - Single-cycle commands: IDLE → EXEC → RESP → HOLD → IDLE. Accept at edge T; pcpi_ready = 1 for exactly the cycle after EXEC (T+2).
  - INIT/NEXT:
    - IDLE → START. pcpi_wait = 1 from START until the cycle in which pcpi_ready is asserted.
    - START: when core_ready = 1, pulse core_init or core_next for one cycle, then → WAIT_ACK.
    - WAIT_ACK: when core_ready = 0, → WAIT_DONE.
    - WAIT_DONE: when core_ready = 1 and core_digest_valid = 1, capture the digest, set digest_ok = 1, clear timeout, → RESP.
  - Watchdog:
    - Counter is reset on START entry and counts in START, WAIT_ACK and WAIT_DONE.
    - On reaching TIMEOUT_CYCLES: timeout = 1, digest_ok = 0, digest unchanged, core_reset_n pulsed low for 2 cycles, → RESP. The CPU is never hung.
  - RESET: IDLE → CORE_RST (2 cycles) → RESP.
  - HOLD: one cycle that ignores pcpi_valid, because picorv32 keeps pcpi_valid high for one cycle after seeing pcpi_ready.
- core_block is continuously driven from the block registers.
- LW/LWI issued after an INIT/NEXT has completed only modify the buffer; there is no race, because the block is single-issue by construction.

Test Plan:
- Reset with pcpi_valid = 1 and a matching insn → no pcpi_ready; after release, STATUS returns 0x00000002 (core_ready = 1, all else 0).
- 16× LWI with rs1 = i → block[i] = i, ptr wraps to 0; STATUS bits [7:4] = 0.
- Load the "abc" padded block, INIT with rs1 = 1, 8× DIGEST → rd = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; pcpi_ready is a single-cycle pulse; pcpi_wait stays high throughout.
- Model core holds core_ready = 0 forever; issue NEXT → pcpi_ready exactly TIMEOUT_CYCLES cycles (±2) after START; STATUS shows timeout = 1, digest_ok = 0; core_reset_n pulsed low for 2 cycles.
- LW with rs2 = 20 and DIGEST with rs2 = 9 → no buffer change; rd = 0; both complete with pcpi_ready.
- pcpi_valid held high for one cycle after pcpi_ready → no second response; an insn with non-matching funct7 → pcpi_ready never asserts.

Source files
------------

// File: rtl/picorv32_pcpi_sha2_ctrl.sv
// rtl/picorv32_pcpi_sha2_ctrl.sv - PCPI front-end for an external SHA-224/256 compression core
// Holds the message block and digest buffers, sequences the core handshake and guards it with a watchdog.
module picorv32_pcpi_sha2_ctrl #(
  parameter int         BLOCK_WORDS    = 16,
  parameter int         DIGEST_WORDS   = 8,
  parameter logic [6:0] OPCODE         = 7'b0001011,
  parameter logic [6:0] FUNCT7         = 7'b0000000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pcpi_valid,
  input  logic [31:0]               pcpi_insn,
  input  logic [31:0]               pcpi_rs1,
  input  logic [31:0]               pcpi_rs2,
  output logic                      pcpi_wr,
  output logic [31:0]               pcpi_rd,
  output logic                      pcpi_wait,
  output logic                      pcpi_ready,
  output logic                      core_reset_n,
  output logic                      core_init,
  output logic                      core_next,
  output logic                      core_mode,
  output logic [32*BLOCK_WORDS-1:0] core_block,
  input  logic                      core_ready,
  input  logic [32*DIGEST_WORDS-1:0] core_digest,
  input  logic                      core_digest_valid
);

  localparam int PTR_W = $clog2(BLOCK_WORDS);
  localparam int DIG_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] F_LW     = 3'b000;
  localparam logic [2:0] F_INIT   = 3'b001;
  localparam logic [2:0] F_NEXT   = 3'b010;
  localparam logic [2:0] F_DIGEST = 3'b011;
  localparam logic [2:0] F_RESET  = 3'b100;
  localparam logic [2:0] F_STATUS = 3'b101;
  localparam logic [2:0] F_LWI    = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_START, S_WAIT_ACK, S_WAIT_DONE, S_CORE_RST, S_RESP, S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      block_q  [BLOCK_WORDS];
  logic [31:0]      block_d  [BLOCK_WORDS];
  logic [31:0]      digest_q [DIGEST_WORDS];
  logic [31:0]      digest_d [DIGEST_WORDS];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic             digest_ok_q, digest_ok_d;
  logic             mode_q, mode_d;
  logic             rst_cnt_q, rst_cnt_d;
  logic             core_reset_n_q, core_reset_n_d;
  logic             core_init_q, core_init_d;
  logic             core_next_q, core_next_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             long_q, long_d;

  logic       insn_match;
  logic [2:0] funct3;
  logic       wd_active;
  logic       done_now;
  logic       unused_insn;

  assign funct3      = pcpi_insn[14:12];
  assign insn_match  = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7);
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  assign wd_active   = (state_q == S_START) || (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
  assign done_now    = (state_q == S_WAIT_DONE) && core_ready && core_digest_valid;

  always_comb begin
    state_d        = state_q;
    block_d        = block_q;
    digest_d       = digest_q;
    ptr_d          = ptr_q;
    wd_cnt_d       = wd_cnt_q;
    timeout_d      = timeout_q;
    digest_ok_d    = digest_ok_q;
    mode_d         = mode_q;
    cmd_d          = cmd_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    long_d         = long_q;
    core_init_d    = 1'b0;
    core_next_d    = 1'b0;
    core_reset_n_d = 1'b1;
    rst_cnt_d      = 1'b0;

    // A pending second low cycle of the core reset pulse.
    if (rst_cnt_q) begin
      core_reset_n_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (insn_match) begin
          cmd_d  = funct3;
          rs1_d  = pcpi_rs1;
          rs2_d  = pcpi_rs2;
          rd_d   = '0;
          wr_d   = 1'b0;
          long_d = 1'b0;
          case (funct3)
            F_LW, F_LWI, F_DIGEST, F_STATUS: state_d = S_EXEC;
            F_INIT, F_NEXT: begin
              mode_d   = pcpi_rs1[0];
              ptr_d    = '0;
              wd_cnt_d = '0;
              long_d   = 1'b1;
              state_d  = S_START;
            end
            F_RESET: begin
              for (int i = 0; i < BLOCK_WORDS; i++) block_d[i] = '0;
              for (int i = 0; i < DIGEST_WORDS; i++) digest_d[i] = '0;
              ptr_d          = '0;
              timeout_d      = 1'b0;
              digest_ok_d    = 1'b0;
              core_reset_n_d = 1'b0;
              rst_cnt_d      = 1'b1;
              long_d         = 1'b1;
              state_d        = S_CORE_RST;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_EXEC: begin
        case (cmd_q)
          F_LW: begin
            if (rs2_q < 32'(BLOCK_WORDS)) block_d[rs2_q[PTR_W-1:0]] = rs1_q;
          end
          F_LWI: begin
            block_d[ptr_q] = rs1_q;
            ptr_d          = ptr_q + PTR_W'(1);
          end
          F_DIGEST: begin
            wr_d = 1'b1;
            if (rs2_q < 32'(DIGEST_WORDS)) rd_d = digest_q[rs2_q[DIG_W-1:0]];
          end
          F_STATUS: begin
            wr_d = 1'b1;
            rd_d = {24'b0, 4'(ptr_q), timeout_q, digest_ok_q, core_ready, 1'b0};
          end
          default: ;
        endcase
        state_d = S_RESP;
      end
      S_START: begin
        if (core_ready) begin
          if (cmd_q == F_INIT) core_init_d = 1'b1;
          else                 core_next_d = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!core_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_now) begin
          for (int i = 0; i < DIGEST_WORDS; i++) begin
            digest_d[i] = core_digest[32*(DIGEST_WORDS-1-i) +: 32];
          end
          digest_ok_d = 1'b1;
          timeout_d   = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_CORE_RST: begin
        if (!rst_cnt_q) state_d = S_RESP;
      end
      S_RESP: state_d = S_HOLD;
      S_HOLD: begin
        // picorv32 still shows pcpi_valid for the instruction just retired.
        rd_d    = '0;
        wr_d    = 1'b0;
        long_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: a completed digest in the same cycle wins over expiry.
    if (wd_active) begin
      if ((wd_cnt_q == WD_LAST) && !done_now) begin
        timeout_d      = 1'b1;
        digest_ok_d    = 1'b0;
        core_init_d    = 1'b0;
        core_next_d    = 1'b0;
        core_reset_n_d = 1'b0;
        rst_cnt_d      = 1'b1;
        state_d        = S_RESP;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < BLOCK_WORDS; i++) block_q[i] <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
      ptr_q          <= '0;
      wd_cnt_q       <= '0;
      timeout_q      <= 1'b0;
      digest_ok_q    <= 1'b0;
      mode_q         <= 1'b1;
      rst_cnt_q      <= 1'b0;
      core_reset_n_q <= 1'b0;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      cmd_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      wr_q           <= 1'b0;
      long_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      block_q        <= block_d;
      digest_q       <= digest_d;
      ptr_q          <= ptr_d;
      wd_cnt_q       <= wd_cnt_d;
      timeout_q      <= timeout_d;
      digest_ok_q    <= digest_ok_d;
      mode_q         <= mode_d;
      rst_cnt_q      <= rst_cnt_d;
      core_reset_n_q <= core_reset_n_d;
      core_init_q    <= core_init_d;
      core_next_q    <= core_next_d;
      cmd_q          <= cmd_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      long_q         <= long_d;
    end
  end

  generate
    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_block
      assign core_block[32*(BLOCK_WORDS-1-g) +: 32] = block_q[g];
    end
  endgenerate

  assign pcpi_ready   = (state_q == S_RESP);
  assign pcpi_wr      = pcpi_ready && wr_q;
  assign pcpi_rd      = rd_q;
  assign pcpi_wait    = wd_active || (state_q == S_CORE_RST) || (pcpi_ready && long_q);
  assign core_reset_n = core_reset_n_q;
  assign core_init    = core_init_q;
  assign core_next    = core_next_q;
  assign core_mode    = mode_q;

endmodule

// File: tb/tb_picorv32_pcpi_sha2_ctrl.sv
// tb/tb_picorv32_pcpi_sha2_ctrl.sv - directed bench with a behavioural SHA-256 core model
module tb_picorv32_pcpi_sha2_ctrl;
  localparam int         BW  = 16;
  localparam int         DW  = 8;
  localparam int         TO  = 64;
  localparam logic [6:0] OPC = 7'b0001011;
  localparam logic [6:0] F7  = 7'b0000000;
  localparam logic [2:0] F_LW = 3'b000, F_INIT = 3'b001, F_NEXT = 3'b010, F_DIGEST = 3'b011;
  localparam logic [2:0] F_RESET = 3'b100, F_STATUS = 3'b101, F_LWI = 3'b110;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] H256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] H224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                   32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] EXP_DIG [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                          32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  logic           clk = 1'b0;
  logic           reset_n;
  logic           pcpi_valid;
  logic [31:0]    pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic           pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0]    pcpi_rd;
  logic           core_reset_n, core_init, core_next, core_mode;
  logic [32*BW-1:0] core_block;
  logic           core_ready, core_digest_valid;
  logic [32*DW-1:0] core_digest;

  always #5 clk = ~clk;

  picorv32_pcpi_sha2_ctrl #(.BLOCK_WORDS(BW), .DIGEST_WORDS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .core_reset_n(core_reset_n), .core_init(core_init), .core_next(core_next), .core_mode(core_mode),
    .core_block(core_block), .core_ready(core_ready), .core_digest(core_digest),
    .core_digest_valid(core_digest_valid));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural hash core: a few busy cycles per block; 'stuck' hides core_ready.
  logic         m_rdy = 1'b1;
  logic         m_val = 1'b0;
  logic [255:0] m_h = '0;
  int           m_busy = 0;
  logic         stuck = 1'b0;

  always @(posedge clk) begin
    if (core_reset_n === 1'b0) begin
      m_rdy <= 1'b1; m_val <= 1'b0; m_busy <= 0; m_h <= '0;
    end else if ((core_init === 1'b1 || core_next === 1'b1) && m_rdy) begin
      m_h    <= sha256_blk(core_init ? (core_mode ? H256 : H224) : m_h, core_block);
      m_rdy  <= 1'b0; m_val <= 1'b0; m_busy <= 6;
    end else if (m_busy > 1) begin
      m_busy <= m_busy - 1;
    end else if (m_busy == 1) begin
      m_busy <= 0; m_rdy <= 1'b1; m_val <= 1'b1;
    end
  end

  assign core_ready        = m_rdy & ~stuck;
  assign core_digest       = m_h;
  assign core_digest_valid = m_val;

  int   ready_cnt = 0, double_cnt = 0, rn_run = 0, rn_last = 0;
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    if (pcpi_ready === 1'b1) begin
      ready_cnt <= ready_cnt + 1;
      if (ready_prev) double_cnt <= double_cnt + 1;
    end
    ready_prev <= (pcpi_ready === 1'b1);
    if (core_reset_n === 1'b0) rn_run <= rn_run + 1;
    else begin
      if (rn_run != 0) rn_last <= rn_run;
      rn_run <= 0;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input int budget, output logic got, output logic [31:0] rd, output logic wr,
                       output int cyc, output logic wok);
    got = 1'b0; rd = '0; wr = 1'b0; cyc = 0; wok = 1'b1;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = {f7, 5'd0, 5'd0, f3, 5'd0, OPC};
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pcpi_ready === 1'b1) begin
        got = 1'b1; rd = pcpi_rd; wr = pcpi_wr;
      end else if (pcpi_wait !== 1'b1) begin
        wok = 1'b0;
      end
    end
    if (got) repeat (2) @(negedge clk);
    pcpi_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] rd, output logic wr, output int cyc, output logic wok);
    int   c0;
    logic got;
    c0 = ready_cnt;
    issue(f3, F7, a, b, 200, got, rd, wr, cyc, wok);
    check({tag, "_ready"}, 32'(got), 32'd1);
    check({tag, "_pulses"}, 32'(ready_cnt - c0), 32'd1);
  endtask

  initial begin
    logic [31:0]  rd;
    logic         wr, wok, got;
    int           cyc, c0;
    logic [511:0] exp_blk;

    reset_n = 1'b0; pcpi_valid = 1'b1;
    pcpi_insn = {F7, 10'd0, F_STATUS, 5'd0, OPC}; pcpi_rs1 = '0; pcpi_rs2 = '0;
    repeat (4) @(negedge clk);
    check("rst_ready", 32'(pcpi_ready), 32'd0);
    check("rst_wr", 32'(pcpi_wr), 32'd0);
    check("rst_wait", 32'(pcpi_wait), 32'd0);
    check("rst_rd", pcpi_rd, 32'd0);
    check("rst_init_next", {30'd0, core_init, core_next}, 32'd0);
    check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    check("rst_core_mode", 32'(core_mode), 32'd1);
    pcpi_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check("rel_core_reset_n", 32'(core_reset_n), 32'd1);
    check("rst_no_ready", 32'(ready_cnt), 32'd0);

    cmd("status0", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status0_rd", rd, 32'h0000_0002);
    check("status0_wr", 32'(wr), 32'd1);
    check("status0_latency", 32'(cyc), 32'd2);

    for (int i = 0; i < 5; i++) cmd("lwi", F_LWI, 32'(i), 32'h55, rd, wr, cyc, wok);
    check("lwi_wr", 32'(wr), 32'd0);
    cmd("status5", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status5_rd", rd, 32'h0000_0052);
    for (int i = 5; i < BW; i++) cmd("lwi", F_LWI, 32'(i), 0, rd, wr, cyc, wok);
    for (int i = 0; i < BW; i++) exp_blk[511-32*i -: 32] = 32'(i);
    check("lwi_block", 32'(core_block === exp_blk), 32'd1);
    cmd("status_wrap", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status_wrap_rd", rd, 32'h0000_0002);

    cmd("lwi_abc", F_LWI, 32'h6162_6380, 0, rd, wr, cyc, wok);
    for (int i = 1; i < 15; i++) cmd("lw_abc", F_LW, 0, 32'(i), rd, wr, cyc, wok);
    cmd("lw_abc15", F_LW, 32'h18, 15, rd, wr, cyc, wok);
    exp_blk = '0;
    exp_blk[511:480] = 32'h6162_6380;
    exp_blk[31:0]    = 32'h18;
    check("abc_block", 32'(core_block === exp_blk), 32'd1);
    cmd("status_ptr1", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status_ptr1_rd", rd, 32'h0000_0012);

    cmd("init", F_INIT, 32'd1, 0, rd, wr, cyc, wok);
    check("init_wait", 32'(wok), 32'd1);
    check("init_wr", 32'(wr), 32'd0);
    cmd("status_ok", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status_ok_rd", rd, 32'h0000_0006);
    for (int i = 0; i < DW; i++) begin
      cmd("digest", F_DIGEST, 0, 32'(i), rd, wr, cyc, wok);
      check($sformatf("digest%0d", i), rd, EXP_DIG[i]);
    end
    check("digest_wr", 32'(wr), 32'd1);

    stuck = 1'b1;
    cmd("next_to", F_NEXT, 32'd1, 0, rd, wr, cyc, wok);
    check("timeout_latency", 32'(((cyc - 1) >= TO - 2) && ((cyc - 1) <= TO + 2)), 32'd1);
    check("timeout_wr", 32'(wr), 32'd0);
    check("timeout_core_reset_len", 32'(rn_last), 32'd2);
    cmd("status_to", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status_to_rd", rd, 32'h0000_0008);
    cmd("digest_kept", F_DIGEST, 0, 0, rd, wr, cyc, wok);
    check("digest_kept_rd", rd, 32'hba78_16bf);
    stuck = 1'b0;

    cmd("lw_oor", F_LW, 32'hdead_beef, 32'd20, rd, wr, cyc, wok);
    check("lw_oor_block", 32'(core_block === exp_blk), 32'd1);
    cmd("digest_oor", F_DIGEST, 0, 32'd9, rd, wr, cyc, wok);
    check("digest_oor_rd", rd, 32'd0);
    check("digest_oor_wr", 32'(wr), 32'd1);

    c0 = ready_cnt;
    issue(F_STATUS, 7'b0000001, 0, 0, 20, got, rd, wr, cyc, wok);
    check("bad_funct7", 32'(got), 32'd0);
    issue(3'b111, F7, 0, 0, 20, got, rd, wr, cyc, wok);
    check("bad_funct3", 32'(got), 32'd0);
    check("no_stray_ready", 32'(ready_cnt - c0), 32'd0);

    cmd("reset_cmd", F_RESET, 0, 0, rd, wr, cyc, wok);
    check("reset_cmd_wr", 32'(wr), 32'd0);
    check("reset_cmd_block", 32'(core_block === '0), 32'd1);
    cmd("status_rst", F_STATUS, 0, 0, rd, wr, cyc, wok);
    check("status_rst_rd", rd, 32'h0000_0002);
    cmd("digest_rst", F_DIGEST, 0, 0, rd, wr, cyc, wok);
    check("digest_rst_rd", rd, 32'd0);

    check("ready_single_cycle", 32'(double_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish before 500000");
    $fatal(1, "bench time limit");
  end

endmodule
